// File: rtl/weight_ram_loader.sv
// Purpose : streams NUM_WEIGHTS weight bytes from a valid/ready source into the weight RAM,
//           with an optional trailing checksum byte that is compared against the running sum.
// Latency : a byte accepted on cycle t is written on cycle t+1 (one-cycle wr_en strobe).
// Backpressure: in_ready is decoded from the state register only (high in LOAD/CHECK);
//               it never depends on in_valid and drops in the cycle DONE is entered.
//
// Configuration macro: WRL_CHECKSUM_EN (undefined = no CHECK state, err tied to 0).
//
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, abort        - begin a load (ignored while busy) / cancel an in-progress load
//   in_data/in_valid/in_ready - incoming weight byte stream
//   wr_en/wr_addr/wr_data     - weight RAM write port
//   busy, done, err     - status: loading, last load completed, checksum mismatch
module weight_ram_loader #(
    parameter int NUM_WEIGHTS = 320,
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
`ifdef WRL_CHECKSUM_EN
        S_CHECK = 2'd2,
`endif
        S_DONE  = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] count;
    logic                  xfer;
    logic                  load_xfer;
    logic                  start_ok;

    assign xfer      = in_valid & in_ready;
    assign load_xfer = xfer & (state == S_LOAD);
    // start only counts when idle or done; while busy it is dropped, so abort wins a tie.
    assign start_ok  = start & ((state == S_IDLE) | (state == S_DONE));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (load_xfer && (count == LAST_ADDR)) begin
`ifdef WRL_CHECKSUM_EN
                    state_nxt = S_CHECK;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
`ifdef WRL_CHECKSUM_EN
            S_CHECK: begin
                if (abort)     state_nxt = S_IDLE;
                else if (xfer) state_nxt = S_DONE;
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from the state register alone
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef WRL_CHECKSUM_EN
            S_CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Write port and address counter. A transfer coinciding with abort still gets its strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= load_xfer;
            if (load_xfer) begin
                wr_addr <= count;
                wr_data <= in_data;
            end
            if (start_ok)       count <= '0;
            else if (load_xfer) count <= count + 1'b1;
        end
    end

`ifdef WRL_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;
    logic                  err_q;

    // Sum wraps modulo 2**DATA_WIDTH by construction of its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            err_q <= 1'b0;
        end else begin
            if (start_ok)       sum <= '0;
            else if (load_xfer) sum <= sum + in_data;

            if (start_ok || (busy && abort))
                err_q <= 1'b0;
            else if ((state == S_CHECK) && xfer)
                err_q <= (in_data != sum);
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_weight_ram_loader.sv
module tb_weight_ram_loader;

    localparam int NW = 320;
    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy, done, err;

    int checks = 0;
    int errors = 0;

    int wq_a[$];
    int wq_d[$];

    weight_ram_loader #(.NUM_WEIGHTS(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Log every write strobe, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wq_a.push_back(int'(wr_addr));
            wq_d.push_back(int'(wr_data));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 0);
        chk({tag, "_wr_en"},    32'(wr_en),    0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  0);
        chk({tag, "_wr_data"},  32'(wr_data),  0);
        chk({tag, "_busy"},     32'(busy),     0);
        chk({tag, "_done"},     32'(done),     0);
        chk({tag, "_err"},      32'(err),      0);
    endtask

    task automatic do_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Deliver n transfers; data is ones ? 0x01 : (base+idx) & 0x3F.
    // in_valid is left high after the last counted transfer, which happens on the next rising edge.
    task automatic stream(input int n, input bit rnd, input bit ones, input int base);
        int sent = 0;
        for (int cyc = 0; cyc < 4000 && sent < n; cyc++) begin
            @(negedge clk);
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = ones ? 8'h01 : 8'((base + sent) & 63);
            if (in_valid && in_ready) sent++;
        end
        chk("stream_cnt", 32'(sent), 32'(n));
    endtask

    // Checks around the final write; trailer is the checksum byte, or a probe byte sent in DONE.
    task automatic post_load(input logic [7:0] last_dat, input logic [7:0] trailer, input bit exp_err);
        @(negedge clk);
        in_valid = 1'b0;
        chk("last_wr_en",   32'(wr_en),   1);
        chk("last_wr_addr", 32'(wr_addr), NW - 1);
        chk("last_wr_data", 32'(wr_data), 32'(last_dat));
`ifdef WRL_CHECKSUM_EN
        chk("check_busy",     32'(busy),     1);
        chk("check_in_ready", 32'(in_ready), 1);
        chk("check_done",     32'(done),     0);
        in_valid = 1'b1;
        in_data  = trailer;
        @(negedge clk);
        in_valid = 1'b0;
        chk("cs_done",  32'(done),  1);
        chk("cs_err",   32'(err),   32'(exp_err));
        chk("cs_busy",  32'(busy),  0);
        chk("cs_wr_en", 32'(wr_en), 0);
`else
        chk("done_at_last", 32'(done),     1);
        chk("busy_at_last", 32'(busy),     0);
        chk("rdy_at_last",  32'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = trailer;
        @(negedge clk);
        in_valid = 1'b0;
        chk("done_held",  32'(done),  1);
        chk("done_wr_en", 32'(wr_en), 0);
        chk("done_err",   32'(err),   32'(exp_err));
`endif
    endtask

    task automatic check_writes(input int n, input bit ones);
        int bad = 0;
        chk("wr_count", 32'(wq_a.size()), 32'(n));
        for (int i = 0; i < wq_a.size(); i++) begin
            if (wq_a[i] != i) bad++;
            if (wq_d[i] != (ones ? 1 : (i & 63))) bad++;
        end
        chk("wr_seq_bad", 32'(bad), 0);
        wq_a.delete();
        wq_d.delete();
    endtask

    initial begin
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        rst_n    = 1'b1;
        #3 rst_n = 1'b0;
        #2 check_all_zero("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_busy",     32'(busy),     0);

        // Full load, continuous valid (sum of 0..63 x5 = 0x60)
        do_start();
        chk("load_busy",     32'(busy),     1);
        chk("load_in_ready", 32'(in_ready), 1);
        chk("load_done",     32'(done),     0);
        stream(NW, 1'b0, 1'b0, 0);
        post_load(8'h3F, 8'h60, 1'b0);
        check_writes(NW, 1'b0);

        // Restart from DONE, toggling valid
        do_start();
        chk("restart_done_clr", 32'(done), 0);
        stream(NW, 1'b1, 1'b0, 0);
        post_load(8'h3F, 8'h60, 1'b0);
        check_writes(NW, 1'b0);

        // Abort after 100 transfers
        do_start();
        stream(100, 1'b0, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",     32'(busy),     0);
        chk("abort_done",     32'(done),     0);
        chk("abort_in_ready", 32'(in_ready), 0);
        chk("abort_err",      32'(err),      0);
        repeat (2) @(negedge clk);
        check_writes(100, 1'b0);

        // Restart at addr 0; start while busy ignored; start+abort -> abort wins
        do_start();
        stream(5, 1'b0, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_busy", 32'(busy), 1);
        stream(3, 1'b0, 1'b0, 5);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        abort    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_done", 32'(done), 0);
        check_writes(8, 1'b0);

        // Reset mid-load after 200 transfers
        do_start();
        stream(200, 1'b1, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_all_zero("midrst");
        check_writes(200, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_strobe_after_rst", 32'(wq_a.size()), 0);
        do_start();
        stream(NW, 1'b0, 1'b0, 0);
        post_load(8'h3F, 8'h60, 1'b0);
        check_writes(NW, 1'b0);

`ifdef WRL_CHECKSUM_EN
        // 320 x 0x01 sums to 0x40
        do_start();
        stream(NW, 1'b0, 1'b1, 0);
        post_load(8'h01, 8'h40, 1'b0);
        check_writes(NW, 1'b1);
        do_start();
        chk("err_clr_on_start", 32'(err), 0);
        stream(NW, 1'b0, 1'b1, 0);
        post_load(8'h01, 8'h41, 1'b1);
        check_writes(NW, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weight_ram_loader.md
WEIGHT_RAM_LOADER -- requirements
Module: weight_ram_loader

Interface
REQ-001 The module SHALL have parameter NUM_WEIGHTS, default 320, giving the number of weight bytes written per load.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 9, giving the weight RAM address width.
REQ-003 The module SHALL have parameter DATA_WIDTH, default 8, giving the weight width, matching the MAC operand.
REQ-004 Port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port start  input  1  one-cycle request to begin a load.
REQ-007 Port abort  input  1  cancels an in-progress load.
REQ-008 Port in_data  input  DATA_WIDTH  incoming weight byte.
REQ-009 Port in_valid  input  1  in_data is valid.
REQ-010 Port in_ready  output  1  loader accepts in_data this cycle.
REQ-011 Port wr_en  output  1  weight RAM write strobe.
REQ-012 Port wr_addr  output  ADDR_WIDTH  weight RAM write address.
REQ-013 Port wr_data  output  DATA_WIDTH  weight RAM write data.
REQ-014 Port busy  output  1  high while in LOAD or CHECK.
REQ-015 Port done  output  1  last load completed; held until next start or reset.
REQ-016 Port err  output  1  checksum mismatch on last load; constant 0 when WRL_CHECKSUM_EN is undefined.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, CHECK, DONE; CHECK exists only when WRL_CHECKSUM_EN is defined.
REQ-018 IDLE/DONE + start SHALL enter LOAD next cycle; word counter cleared, done and err cleared.
REQ-019 start while busy SHALL be ignored.
REQ-020 in_ready SHALL be 1 exactly in LOAD and CHECK, registered, never combinationally dependent on in_valid.
REQ-021 A transfer occurs on a cycle where in_valid and in_ready are both 1; in_data is not captured otherwise.
REQ-022 A transfer in LOAD SHALL produce, one cycle later, wr_en=1 for exactly one cycle, wr_addr=counter value at transfer, wr_data=captured byte.
REQ-023 The counter SHALL increment per LOAD transfer and addresses SHALL run 0 .. NUM_WEIGHTS-1 with no wrap or skip.
REQ-024 The transfer at address NUM_WEIGHTS-1 SHALL move LOAD to CHECK (macro defined) or DONE (macro undefined) next cycle; in_ready drops in that same next cycle when entering DONE.
REQ-025 In DONE, done=1, busy=0, wr_en=0 apart from the final trailing write strobe issued on DONE entry.
REQ-026 abort in LOAD or CHECK SHALL return to IDLE next cycle with done=0, err=0; a write strobe for a transfer in the same cycle as abort SHALL still be issued; abort in IDLE/DONE is ignored.
REQ-027 abort and start in the same cycle: abort SHALL win if busy, start wins otherwise.
REQ-028 NUM_WEIGHTS SHALL not exceed 2**ADDR_WIDTH; out-of-range values are unsupported.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, counter 0, checksum 0, and in_ready, wr_en, wr_addr, wr_data, busy, done, err to 0, including mid-load; no write strobe after reset deassertion until a new transfer.

Configuration
REQ-030 Macro WRL_CHECKSUM_EN defined: the module SHALL sum all NUM_WEIGHTS bytes modulo 2**DATA_WIDTH; in CHECK one more byte is accepted (not written to RAM), err is set to 1 if it differs from the sum, then the module enters DONE.
REQ-031 Macro WRL_CHECKSUM_EN undefined: no checksum logic or CHECK state; err is tied to 0; exactly NUM_WEIGHTS bytes are accepted per load.

Verification
REQ-032 Start, stream bytes 0x00..0x3F repeating with continuous valid (NUM_WEIGHTS=320) -> 320 strobes, addr 0..0x13F, data matches, done=1 one cycle after the last strobe's transfer+1, busy=0.
REQ-033 Same stream with in_valid toggled pseudo-randomly -> identical write sequence, no duplicate or missing addresses.
REQ-034 Abort after 100 transfers -> strobes for addr 0..99 only, IDLE, done=0; new start restarts at addr 0.
REQ-035 rst_n low after 200 transfers -> all outputs 0 at once; no further wr_en; start afterwards writes from addr 0.
REQ-036 Checksum on: 320 bytes of 0x01, trailer 0x40 -> err=0, done=1; trailer 0x41 -> err=1, done=1; no write at addr 0x140.
REQ-037 start pulsed during LOAD and start+abort together in LOAD -> start ignored; abort honored, IDLE next cycle.
